range_sum: RTL and testbench

Iterative, parametrised range accumulator: sums the arithmetic sequence lo, lo+step, lo+2·step, … ≤ hi, one term per clock. It is the sequential successor to the single-cycle summing block in the arithmetic examples. It adds a valid/ready request handshake, a programmable stride, a term counter, a done pulse and saturating overflow detection. It sits behind any controller that issues range-sum jobs and polls or waits on `done`.

---
 rtl/range_sum_if.sv | 26 ++
 rtl/range_sum.sv | 98 +++++++++
 tb/tb_range_sum.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/range_sum_if.sv
// Request/response bundle between a job controller (master) and the range_sum engine (slave).
interface range_sum_if #(
    parameter int W  = 8,
    parameter int SW = 17
);
    logic          req;
    logic          ready;
    logic [W-1:0]  lo;
    logic [W-1:0]  hi;
    logic [W-1:0]  step;
    logic          busy;
    logic          done;
    logic [SW-1:0] sum;
    logic [W:0]    count;
    logic          ovf;

    modport master (
        output req, lo, hi, step,
        input  ready, busy, done, sum, count, ovf
    );

    modport slave (
        input  req, lo, hi, step,
        output ready, busy, done, sum, count, ovf
    );
endinterface

// File: rtl/range_sum.sv
// Iterative range accumulator: adds lo, lo+step, ... <= hi one term per clock,
// saturating the sum and flagging overflow when the accumulator would wrap.
module range_sum #(
    parameter int W  = 8,
    parameter int SW = 17
) (
    input logic       i_clk,
    input logic       i_rst,
    range_sum_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_step;
    logic [W:0]    r_cur;
    logic [W:0]    r_count;
    logic [SW-1:0] r_sum;
    logic          r_ovf;

    logic          w_accept;
    logic          w_empty;
    logic [W-1:0]  w_eff_step;
    logic [W:0]    w_next_cur;
    logic          w_last;
    logic [SW:0]   w_add;

    assign w_accept   = bus.req && (r_state == IDLE);
    assign w_empty    = bus.lo > bus.hi;
    assign w_eff_step = (bus.step == '0) ? W'(1) : bus.step;

    // One extra bit on the term so hi near 2^W-1 terminates instead of wrapping.
    assign w_next_cur = r_cur + {1'b0, r_step};
    assign w_last     = w_next_cur > {1'b0, r_hi};
    assign w_add      = {1'b0, r_sum} + (SW+1)'(r_cur);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_empty ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Results are held from the end of a job until the next accept.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_hi    <= '0;
            r_step  <= '0;
            r_cur   <= '0;
            r_sum   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_hi    <= bus.hi;
            r_step  <= w_eff_step;
            r_cur   <= {1'b0, bus.lo};
            r_sum   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (r_state == RUN) begin
            r_cur   <= w_next_cur;
            r_count <= r_count + (W+1)'(1);
            if (r_ovf || w_add[SW]) begin
                r_sum <= '1;
                r_ovf <= 1'b1;
            end else begin
                r_sum <= w_add[SW-1:0];
            end
        end
    end

    assign bus.ready = (r_state == IDLE);
    assign bus.busy  = (r_state == RUN);
    assign bus.done  = (r_state == DONE);
    assign bus.sum   = r_sum;
    assign bus.count = r_count;
    assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_range_sum.sv
// Scoreboard bench for range_sum: directed jobs push expected results,
// per-DUT monitors pop and compare whenever done is presented.
module tb_range_sum;
    localparam int W   = 8;
    localparam int SW  = 17;
    localparam int SWB = 12;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    range_sum_if #(.W(W), .SW(SW))  busA();
    range_sum_if #(.W(W), .SW(SWB)) busB();

    range_sum #(.W(W), .SW(SW))  dutA (.i_clk(clk), .i_rst(rst), .bus(busA.slave));
    range_sum #(.W(W), .SW(SWB)) dutB (.i_clk(clk), .i_rst(rst), .bus(busB.slave));

    typedef struct {
        int unsigned sum;
        int unsigned count;
        bit          ovf;
        string       tag;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];
    exp_t expA;
    exp_t expB;
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && busA.done === 1'b1) begin
            if (qA.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDoneA: got done=1 expected done=0");
            end else begin
                expA = qA.pop_front();
                checkOutput({expA.tag, ".sum"},   64'(busA.sum),   64'(expA.sum));
                checkOutput({expA.tag, ".count"}, 64'(busA.count), 64'(expA.count));
                checkOutput({expA.tag, ".ovf"},   64'(busA.ovf),   64'(expA.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && busB.done === 1'b1) begin
            if (qB.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDoneB: got done=1 expected done=0");
            end else begin
                expB = qB.pop_front();
                checkOutput({expB.tag, ".sum"},   64'(busB.sum),   64'(expB.sum));
                checkOutput({expB.tag, ".count"}, 64'(busB.count), 64'(expB.count));
                checkOutput({expB.tag, ".ovf"},   64'(busB.ovf),   64'(expB.ovf));
            end
        end
    end

    task automatic waitReadyA();
        int guard = 0;
        @(negedge clk);
        while (busA.ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL readyTimeoutA: got ready=%b expected 1", busA.ready);
        end
    endtask

    // Issue one job on DUT A and wait (bounded) for its done pulse.
    task automatic applyStimulus(input int lo, input int hi, input int step,
                                 input int expSum, input int expCount, input bit expOvf,
                                 input string tag, input bit noisy,
                                 output int latency, output bit sawBusy);
        exp_t e;
        waitReadyA();
        busA.lo   = W'(lo);
        busA.hi   = W'(hi);
        busA.step = W'(step);
        busA.req  = 1'b1;
        e.sum   = expSum;
        e.count = expCount;
        e.ovf   = expOvf;
        e.tag   = tag;
        qA.push_back(e);
        @(posedge clk);
        #1;
        busA.req = 1'b0;
        latency  = 0;
        sawBusy  = 1'b0;
        while (1) begin
            @(negedge clk);
            latency++;
            if (busA.busy === 1'b1) sawBusy = 1'b1;
            if (busA.done === 1'b1) break;
            if (latency > 400) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s.doneTimeout: got no done expected done within 400 cycles", tag);
                break;
            end
            if (noisy && latency < 40) begin
                busA.req = 1'b1;
                busA.lo  = W'($urandom);
                busA.hi  = W'($urandom);
            end else begin
                busA.req = 1'b0;
            end
        end
        busA.req = 1'b0;
    endtask

    initial begin
        int lat;
        bit sawBusy;
        int guard;
        exp_t eb;

        rst       = 1'b0;
        busA.req  = 1'b0;
        busA.lo   = '0;
        busA.hi   = '0;
        busA.step = '0;
        busB.req  = 1'b0;
        busB.lo   = '0;
        busB.hi   = '0;
        busB.step = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.ready", 64'(busA.ready), 64'd1);
        checkOutput("reset.busy",  64'(busA.busy),  64'd0);
        checkOutput("reset.done",  64'(busA.done),  64'd0);
        checkOutput("reset.sum",   64'(busA.sum),   64'd0);
        checkOutput("reset.count", 64'(busA.count), 64'd0);
        checkOutput("reset.ovf",   64'(busA.ovf),   64'd0);
        rst = 1'b1;

        applyStimulus(1, 100, 1, 5050, 100, 1'b0, "j1to100", 1'b0, lat, sawBusy);
        checkOutput("j1to100.latency", 64'(lat), 64'd101);
        @(negedge clk);
        checkOutput("j1to100.readyAfter", 64'(busA.ready), 64'd1);
        checkOutput("j1to100.doneOnce",   64'(busA.done),  64'd0);
        checkOutput("j1to100.sumHeld",    64'(busA.sum),   64'd5050);

        applyStimulus(0, 255, 1, 32640, 256, 1'b0, "j0to255", 1'b0, lat, sawBusy);
        checkOutput("j0to255.latency", 64'(lat), 64'd257);
        applyStimulus(255, 255, 1, 255, 1, 1'b0, "j255", 1'b0, lat, sawBusy);
        checkOutput("j255.latency", 64'(lat), 64'd2);
        applyStimulus(3, 20, 4, 55, 5, 1'b0, "step4", 1'b0, lat, sawBusy);
        checkOutput("step4.latency", 64'(lat), 64'd6);
        applyStimulus(3, 20, 0, 207, 18, 1'b0, "step0", 1'b0, lat, sawBusy);
        checkOutput("step0.latency", 64'(lat), 64'd19);
        applyStimulus(10, 5, 1, 0, 0, 1'b0, "empty", 1'b0, lat, sawBusy);
        checkOutput("empty.latency", 64'(lat), 64'd1);
        checkOutput("empty.busy",    64'(sawBusy), 64'd0);
        applyStimulus(1, 100, 1, 5050, 100, 1'b0, "noisyReq", 1'b1, lat, sawBusy);
        checkOutput("noisyReq.latency", 64'(lat), 64'd101);

        // Reset in the middle of a job: nothing pushed, so any done pulse is flagged.
        waitReadyA();
        busA.lo   = W'(1);
        busA.hi   = W'(100);
        busA.step = W'(1);
        busA.req  = 1'b1;
        @(posedge clk);
        #1;
        busA.req = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        checkOutput("midRst.partialSum",   64'(busA.sum),   64'd1225);
        checkOutput("midRst.partialCount", 64'(busA.count), 64'd49);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("midRst.ready", 64'(busA.ready), 64'd1);
        checkOutput("midRst.busy",  64'(busA.busy),  64'd0);
        checkOutput("midRst.sum",   64'(busA.sum),   64'd0);
        checkOutput("midRst.count", 64'(busA.count), 64'd0);
        repeat (5) @(negedge clk);
        checkOutput("midRst.stillIdle", 64'(busA.ready), 64'd1);

        // Narrow accumulator on DUT B must saturate.
        busB.lo   = W'(1);
        busB.hi   = W'(100);
        busB.step = W'(1);
        busB.req  = 1'b1;
        eb.sum   = 4095;
        eb.count = 100;
        eb.ovf   = 1'b1;
        eb.tag   = "sat12";
        qB.push_back(eb);
        @(posedge clk);
        #1;
        busB.req = 1'b0;
        guard = 0;
        while (busB.done !== 1'b1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("sat12.latency", 64'(guard), 64'd101);

        repeat (5) @(negedge clk);
        checkOutput("queueA.empty", 64'(qA.size()), 64'd0);
        checkOutput("queueB.empty", 64'(qB.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
